// File: rtl/cmp_result_tracker.sv
// Tracks comparator outcomes: saturating per-outcome tallies, an equal-run lock FSM
// and a sticky error flag for non-one-hot flag samples.
module cmp_result_tracker #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             gt,
  input  logic             eq,
  input  logic             lt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [1:0]       last_res,
  output logic             locked,
  output logic             lock_pulse,
  output logic             unlock_pulse,
  output logic             err
);

  localparam int unsigned RUN_W = 4;
  localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(LOCK_LEN);

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_LT   = 2'b01;
  localparam logic [1:0] RES_EQ   = 2'b10;
  localparam logic [1:0] RES_GT   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_LOCKED,
    S_ERROR
  } state_t;

  state_t           state, state_nxt;
  logic [RUN_W-1:0] run, run_nxt, run_inc;
  logic [CNT_W-1:0] gt_cnt_nxt, eq_cnt_nxt, lt_cnt_nxt;
  logic [1:0]       last_res_nxt;
  logic             err_nxt, lock_pulse_nxt, unlock_pulse_nxt, locked_nxt;
  logic             legal, sample;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Exactly one flag high qualifies as a legal comparator result.
  always_comb begin
    legal = 1'b0;
    case ({gt, eq, lt})
      3'b100, 3'b010, 3'b001: legal = 1'b1;
      default:                legal = 1'b0;
    endcase
  end

  // ERROR is absorbing: samples are ignored until clear.
  assign sample  = in_valid && (state != S_ERROR);
  assign run_inc = (run == RUN_TGT) ? run : run + RUN_W'(1);

  always_comb begin
    state_nxt        = state;
    run_nxt          = run;
    gt_cnt_nxt       = gt_cnt;
    eq_cnt_nxt       = eq_cnt;
    lt_cnt_nxt       = lt_cnt;
    last_res_nxt     = last_res;
    err_nxt          = err;
    lock_pulse_nxt   = 1'b0;
    unlock_pulse_nxt = 1'b0;

    if (clear) begin
      state_nxt    = S_IDLE;
      run_nxt      = '0;
      gt_cnt_nxt   = '0;
      eq_cnt_nxt   = '0;
      lt_cnt_nxt   = '0;
      last_res_nxt = RES_NONE;
      err_nxt      = 1'b0;
    end else if (sample && !legal) begin
      err_nxt   = 1'b1;
      state_nxt = S_ERROR;
    end else if (sample) begin
      if (eq) begin
        eq_cnt_nxt   = sat_inc(eq_cnt);
        last_res_nxt = RES_EQ;
        run_nxt      = run_inc;
        case (state)
          S_IDLE, S_TRACK: begin
            if (run_inc == RUN_TGT) begin
              state_nxt      = S_LOCKED;
              lock_pulse_nxt = 1'b1;
            end else begin
              state_nxt = S_TRACK;
            end
          end
          default: state_nxt = state;
        endcase
      end else begin
        if (gt) begin
          gt_cnt_nxt   = sat_inc(gt_cnt);
          last_res_nxt = RES_GT;
        end else begin
          lt_cnt_nxt   = sat_inc(lt_cnt);
          last_res_nxt = RES_LT;
        end
        run_nxt = '0;
        if (state == S_LOCKED) begin
          unlock_pulse_nxt = 1'b1;
        end
        state_nxt = S_TRACK;
      end
    end

    locked_nxt = (state_nxt == S_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run          <= '0;
      gt_cnt       <= '0;
      eq_cnt       <= '0;
      lt_cnt       <= '0;
      last_res     <= RES_NONE;
      locked       <= 1'b0;
      lock_pulse   <= 1'b0;
      unlock_pulse <= 1'b0;
      err          <= 1'b0;
    end else begin
      run          <= run_nxt;
      gt_cnt       <= gt_cnt_nxt;
      eq_cnt       <= eq_cnt_nxt;
      lt_cnt       <= lt_cnt_nxt;
      last_res     <= last_res_nxt;
      locked       <= locked_nxt;
      lock_pulse   <= lock_pulse_nxt;
      unlock_pulse <= unlock_pulse_nxt;
      err          <= err_nxt;
    end
  end

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Self-checking bench for cmp_result_tracker: directed scenarios plus random
// stimulus compared each cycle against an integer-level reference model.
module tb_cmp_result_tracker;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned LOCK_LEN = 4;
  localparam int          CMAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n, clear, in_valid, gt, eq, lt;
  logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt;
  logic [1:0]       last_res;
  logic             locked, lock_pulse, unlock_pulse, err;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state (plain integers, no FSM encoding)
  int m_gt, m_eq, m_lt, m_run, m_last;
  bit m_locked, m_lp, m_up, m_err;

  cmp_result_tracker #(.CNT_W(CNT_W), .LOCK_LEN(LOCK_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .gt(gt), .eq(eq), .lt(lt),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .last_res(last_res),
    .locked(locked), .lock_pulse(lock_pulse), .unlock_pulse(unlock_pulse), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gt = 0; m_eq = 0; m_lt = 0; m_run = 0; m_last = 0;
    m_locked = 0; m_lp = 0; m_up = 0; m_err = 0;
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Predict the outputs that appear after one clock edge with the given inputs.
  task automatic model_step(input bit v, input bit g, input bit e, input bit l, input bit c);
    int nflags;
    m_lp = 0;
    m_up = 0;
    nflags = int'(g) + int'(e) + int'(l);
    if (c) begin
      model_reset();
    end else if (v && !m_err) begin
      if (nflags != 1) begin
        m_err    = 1;
        m_locked = 0;
      end else if (e) begin
        m_eq   = sat(m_eq);
        m_last = 2;
        m_run  = (m_run + 1 > LOCK_LEN) ? LOCK_LEN : m_run + 1;
        if (!m_locked && m_run == LOCK_LEN) begin
          m_locked = 1;
          m_lp     = 1;
        end
      end else begin
        if (g) begin m_gt = sat(m_gt); m_last = 3; end
        else   begin m_lt = sat(m_lt); m_last = 1; end
        m_run = 0;
        if (m_locked) begin
          m_locked = 0;
          m_up     = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".gt_cnt"},       32'(gt_cnt),       32'(m_gt));
    check({ctx, ".eq_cnt"},       32'(eq_cnt),       32'(m_eq));
    check({ctx, ".lt_cnt"},       32'(lt_cnt),       32'(m_lt));
    check({ctx, ".last_res"},     32'(last_res),     32'(m_last));
    check({ctx, ".locked"},       32'(locked),       32'(m_locked));
    check({ctx, ".lock_pulse"},   32'(lock_pulse),   32'(m_lp));
    check({ctx, ".unlock_pulse"}, 32'(unlock_pulse), 32'(m_up));
    check({ctx, ".err"},          32'(err),          32'(m_err));
  endtask

  task automatic drive(input string ctx, input bit v, input bit g, input bit e,
                       input bit l, input bit c);
    @(negedge clk);
    in_valid = v; gt = g; eq = e; lt = l; clear = c;
    @(posedge clk);
    #1;
    model_step(v, g, e, l, c);
    check_all(ctx);
  endtask

  logic [2:0] bad_pat [5];

  initial begin
    bad_pat[0] = 3'b000; bad_pat[1] = 3'b011; bad_pat[2] = 3'b101;
    bad_pat[3] = 3'b110; bad_pat[4] = 3'b111;

    rst_n = 1'b0; clear = 0; in_valid = 0; gt = 0; eq = 0; lt = 0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: lt, gt, eq
    drive("t1_lt", 1, 0, 0, 1, 0);
    drive("t1_gt", 1, 1, 0, 0, 0);
    drive("t1_eq", 1, 0, 1, 0, 0);
    check("t1_lt_cnt", 32'(lt_cnt), 1);
    check("t1_gt_cnt", 32'(gt_cnt), 1);
    check("t1_eq_cnt", 32'(eq_cnt), 1);
    check("t1_last", 32'(last_res), 2);
    check("t1_locked", 32'(locked), 0);

    // 2: lock after LOCK_LEN eq samples, then unlock on gt
    drive("t2_clr", 0, 0, 0, 0, 1);
    for (int i = 0; i < LOCK_LEN - 1; i++) drive("t2_eq", 1, 0, 1, 0, 0);
    check("t2_prelock", 32'(lock_pulse), 0);
    drive("t2_eq4", 1, 0, 1, 0, 0);
    check("t2_lock_pulse", 32'(lock_pulse), 1);
    check("t2_locked", 32'(locked), 1);
    check("t2_eq_cnt", 32'(eq_cnt), 4);
    drive("t2_eq5", 1, 0, 1, 0, 0);
    check("t2_no_repulse", 32'(lock_pulse), 0);
    drive("t2_gt", 1, 1, 0, 0, 0);
    check("t2_unlock_pulse", 32'(unlock_pulse), 1);
    check("t2_unlocked", 32'(locked), 0);
    check("t2_gt_cnt", 32'(gt_cnt), 1);
    drive("t2_idle", 0, 0, 0, 0, 0);
    check("t2_unlock_once", 32'(unlock_pulse), 0);

    // 3: illegal eq+lt, sticky err, later samples ignored, clear
    drive("t3_bad", 1, 0, 1, 1, 0);
    check("t3_err", 32'(err), 1);
    check("t3_eq_hold", 32'(eq_cnt), 5);
    drive("t3_ign_gt", 1, 1, 0, 0, 0);
    drive("t3_ign_eq", 1, 0, 1, 0, 0);
    check("t3_gt_frozen", 32'(gt_cnt), 1);
    drive("t3_clr", 0, 0, 0, 0, 1);
    check("t3_err_clr", 32'(err), 0);
    check("t3_eq_clr", 32'(eq_cnt), 0);

    // 4: saturation
    for (int i = 0; i < 300; i++) drive("t4_gt", 1, 1, 0, 0, 0);
    check("t4_gt_sat", 32'(gt_cnt), 255);
    check("t4_eq_zero", 32'(eq_cnt), 0);
    check("t4_lt_zero", 32'(lt_cnt), 0);

    // 5: flags ignored without valid, clear drops concurrent sample
    drive("t5_clr", 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) drive("t5_noval", 0, 0, 1, 0, 0);
    check("t5_eq_none", 32'(eq_cnt), 0);
    check("t5_no_lock", 32'(locked), 0);
    drive("t5_clr_eq", 1, 0, 1, 0, 1);
    check("t5_dropped", 32'(eq_cnt), 0);

    // 6: asynchronous reset while locked
    drive("t6_lt", 1, 0, 0, 1, 0);
    for (int i = 0; i < LOCK_LEN; i++) drive("t6_eq", 1, 0, 1, 0, 0);
    check("t6_locked", 32'(locked), 1);
    drive("t6_hold", 0, 0, 0, 0, 0);
    in_valid = 0; eq = 0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    drive("t6_after", 0, 0, 0, 0, 0);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      bit v, g, e, l, c;
      int r;
      logic [2:0] f;
      c = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 99));
      if (r < 3)       f = bad_pat[$urandom_range(0, 4)];
      else if (r < 63) f = 3'b010;
      else if (r < 83) f = 3'b100;
      else             f = 3'b001;
      g = f[2]; e = f[1]; l = f[0];
      drive("rnd", v, g, e, l, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cmp_result_tracker.md
Name: cmp_result_tracker

Overview:
Downstream consumer of the 4-bit magnitude comparator. It samples the comparator's greater, equal and less flags when a qualifying valid strobe is high, and keeps saturating tallies of each outcome. A lock FSM asserts a "locked" status after LOCK_LEN consecutive equal results. Flag combinations that are not one-hot are reported as sticky errors.

Parameters:
CNT_W, 8, width of each outcome tally counter
LOCK_LEN, 4, consecutive equal samples required to lock (legal range 1..15)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous clear of counters, FSM and error
in_valid  input  1  flags are sampled on this cycle
gt  input  1  comparator A>B flag
eq  input  1  comparator A==B flag
lt  input  1  comparator A<B flag
gt_cnt  output  CNT_W  saturating count of valid gt samples
eq_cnt  output  CNT_W  saturating count of valid eq samples
lt_cnt  output  CNT_W  saturating count of valid lt samples
last_res  output  2  last legal result: 00 none, 01 lt, 10 eq, 11 gt
locked  output  1  high while in the LOCKED state
lock_pulse  output  1  one-cycle pulse on entry to LOCKED
unlock_pulse  output  1  one-cycle pulse on exit from LOCKED to TRACK
err  output  1  sticky illegal-flag indicator

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All counters = 0; last_res = 00; locked, lock_pulse, unlock_pulse, err = 0.
  - run counter = 0; FSM state = IDLE.
- All outputs are registered. Each takes effect one clock after the sampling edge.
- Legal sample: in_valid=1 and exactly one of gt/eq/lt is high.
- Illegal sample: in_valid=1 with zero flags or more than one flag high.
  - err is set and held until clear or reset.
  - No counter, last_res or run update occurs.
  - FSM moves to ERROR.
- in_valid=0: flags are ignored and all state holds.
- Counters: on a legal sample, the matching counter increments by 1. It saturates at 2^CNT_W-1 and never wraps.
- run counter (4 bits, internal):
  - Increments on a legal eq sample, saturating at LOCK_LEN.
  - Resets to 0 on a legal gt or lt sample.
- FSM states: IDLE, TRACK, LOCKED, ERROR.
  - IDLE: moves to TRACK on the first legal sample.
    - If LOCK_LEN=1 and that sample is eq, it moves directly to LOCKED and asserts lock_pulse.
  - TRACK: moves to LOCKED when a legal eq sample makes run reach LOCK_LEN. lock_pulse=1 for that one cycle.
  - LOCKED: locked=1. A legal gt/lt sample moves to TRACK, asserts unlock_pulse for one cycle and resets run to 0. Eq samples hold LOCKED with no further pulses.
  - ERROR: absorbing state. locked=0 and counters freeze. Only clear or reset leaves ERROR.
  - An illegal sample in LOCKED goes to ERROR. locked drops and no unlock_pulse is issued.
- clear (synchronous, highest priority after reset):
  - Counters, run, last_res, err and the pulses go to 0; FSM goes to IDLE on the next edge.
  - A sample presented in the same cycle as clear is discarded.
- Reset mid-operation clears everything immediately, regardless of clk.

Test Plan:
1. Reset then 3 legal samples lt,gt,eq -> lt_cnt=1, gt_cnt=1, eq_cnt=1, last_res=10, state TRACK, locked=0.
2. 4 consecutive eq samples (LOCK_LEN=4) -> lock_pulse high exactly on the cycle after the 4th sample, locked=1, eq_cnt=4. A following gt sample -> unlock_pulse for one cycle, locked=0, gt_cnt=1.
3. in_valid=1 with gt=0, eq=1, lt=1 -> err=1 next cycle, counters unchanged. Later legal samples are ignored. clear -> err=0, all counts 0, IDLE.
4. Drive 300 gt samples with CNT_W=8 -> gt_cnt holds at 255, no wrap. eq_cnt and lt_cnt stay 0.
5. Set the eq flag with in_valid=0 for 10 cycles -> no count change, no lock. Then assert clear together with a valid eq sample -> the sample is dropped and eq_cnt=0.
6. Pulse rst_n low between clock edges while locked with nonzero counts -> all outputs 0 immediately, before the next clk edge.
